// File: rtl/conway_pkg.sv
// Shared types and constants for the conway display path.
// Also holds a width helper that never returns less than one bit.
package conway_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } scan_state_t;

    localparam logic [23:0] ALIVE_COLOR_DEF = 24'h00FF00;
    localparam logic [23:0] DEAD_COLOR_DEF  = 24'h000000;

    // Index width for a range of n values; a 1-entry range still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conway_frame_scanner.sv
// Snapshots the conway board on request and streams it one pixel per
// valid/ready handshake, optionally in serpentine order, then pulses frame_done.
module conway_frame_scanner
    import conway_pkg::*;
#(
    parameter int                 ROWS        = 8,
    parameter int                 COLS        = 8,
    parameter int                 COLOR_W     = 24,
    parameter logic [COLOR_W-1:0] ALIVE_COLOR = COLOR_W'(ALIVE_COLOR_DEF),
    parameter logic [COLOR_W-1:0] DEAD_COLOR  = COLOR_W'(DEAD_COLOR_DEF),
    parameter int                 SERPENTINE  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS-1:0]           cells,
    input  logic                           frame_start,
    output logic                           busy,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [COLOR_W-1:0]             pix_data,
    output logic [clog2_min1(ROWS)-1:0]    pix_row,
    output logic [clog2_min1(COLS)-1:0]    pix_col,
    output logic                           pix_last,
    output logic                           frame_done
);

    localparam int N    = ROWS * COLS;
    localparam int IW   = clog2_min1(N);
    localparam int RW   = clog2_min1(ROWS);
    localparam int CW   = clog2_min1(COLS);
    localparam bit SERP = (SERPENTINE != 0);

    scan_state_t     state_reg;
    logic [RW-1:0]   row_reg;
    logic [CW-1:0]   col_reg;
    logic [N-1:0]    snapshot_reg;

    logic            row_rev;
    logic            next_row_rev;
    logic            at_row_end;
    logic            at_last_row;
    logic            is_last;
    logic [CW-1:0]   next_start_col;
    logic [IW-1:0]   pix_idx;
    logic            pix_bit;

    // Scan direction of the current and the following row.
    always_comb begin
        row_rev        = SERP && row_reg[0];
        next_row_rev   = SERP && !row_reg[0];
        at_row_end     = row_rev ? (col_reg == '0) : (col_reg == CW'(COLS - 1));
        at_last_row    = (row_reg == RW'(ROWS - 1));
        is_last        = at_last_row && at_row_end;
        next_start_col = next_row_rev ? CW'(COLS - 1) : '0;
        pix_idx        = IW'(row_reg) * IW'(COLS) + IW'(col_reg);
        pix_bit        = |(snapshot_reg & (N'(1) << pix_idx));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            snapshot_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (frame_start) begin
                        snapshot_reg <= cells;
                        row_reg      <= '0;
                        col_reg      <= '0;
                        state_reg    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pix_ready) begin
                        if (is_last) begin
                            state_reg <= S_DONE;
                        end else if (at_row_end) begin
                            row_reg <= row_reg + 1'b1;
                            col_reg <= next_start_col;
                        end else if (row_rev) begin
                            col_reg <= col_reg - 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // pix_last is gated by valid so an idle 1x1 board does not flag a last pixel.
    always_comb begin
        busy       = (state_reg != S_IDLE);
        pix_valid  = (state_reg == S_STREAM);
        frame_done = (state_reg == S_DONE);
        pix_last   = pix_valid && is_last;
        pix_row    = row_reg;
        pix_col    = col_reg;
        pix_data   = pix_bit ? ALIVE_COLOR : DEAD_COLOR;
    end

endmodule

// File: tb/tb_conway_frame_scanner.sv
// Directed bench for conway_frame_scanner: 8x8 raster, 3x4 serpentine and 1x1
// instances share clock and reset; a per-frame model predicts every pixel.
module tb_conway_frame_scanner;

    logic clk;
    logic rst;
    logic        start_v [3];
    logic        ready_v [3];
    logic [63:0] cells_v [3];

    logic        pv8, busy8, last8, done8;
    logic [23:0] data8;
    logic [2:0]  row8, col8;
    logic        pvs, busys, lasts, dones;
    logic [23:0] datas;
    logic [1:0]  rows_o, cols_o;
    logic        pv1, busy1, last1, done1;
    logic [23:0] data1;
    logic [0:0]  row1, col1;

    int sel;
    logic        o_valid, o_busy, o_last, o_done;
    logic [23:0] o_data;
    logic [7:0]  o_row, o_col;

    int errors;
    int checks;

    conway_frame_scanner #(.ROWS(8), .COLS(8), .SERPENTINE(0)) u8 (
        .clk(clk), .rst(rst), .cells(cells_v[0]), .frame_start(start_v[0]),
        .busy(busy8), .pix_valid(pv8), .pix_ready(ready_v[0]), .pix_data(data8),
        .pix_row(row8), .pix_col(col8), .pix_last(last8), .frame_done(done8)
    );

    conway_frame_scanner #(.ROWS(3), .COLS(4), .SERPENTINE(1)) us (
        .clk(clk), .rst(rst), .cells(cells_v[1][11:0]), .frame_start(start_v[1]),
        .busy(busys), .pix_valid(pvs), .pix_ready(ready_v[1]), .pix_data(datas),
        .pix_row(rows_o), .pix_col(cols_o), .pix_last(lasts), .frame_done(dones)
    );

    conway_frame_scanner #(.ROWS(1), .COLS(1), .SERPENTINE(0)) u1 (
        .clk(clk), .rst(rst), .cells(cells_v[2][0:0]), .frame_start(start_v[2]),
        .busy(busy1), .pix_valid(pv1), .pix_ready(ready_v[2]), .pix_data(data1),
        .pix_row(row1), .pix_col(col1), .pix_last(last1), .frame_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_valid = pv8;  o_busy = busy8; o_last = last8; o_done = done8;
        o_data  = data8; o_row = 8'(row8); o_col = 8'(col8);
        if (sel == 1) begin
            o_valid = pvs;  o_busy = busys; o_last = lasts; o_done = dones;
            o_data  = datas; o_row = 8'(rows_o); o_col = 8'(cols_o);
        end else if (sel == 2) begin
            o_valid = pv1;  o_busy = busy1; o_last = last1; o_done = done1;
            o_data  = data1; o_row = 8'(row1); o_col = 8'(col1);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // rmode 0: ready always high; rmode 1: ready pattern 1,0,0,1 repeating.
    task automatic run_frame(input int rows, input int cols, input int serp,
                             input logic [63:0] snap, input int rmode,
                             input bit mutate, input string tag);
        int k;
        int cyc;
        int r;
        int c;
        int n;
        logic rdy;
        n = rows * cols;
        cells_v[sel] = snap;
        start_v[sel] = 1'b1;
        tick();
        start_v[sel] = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 1000) begin
            r = k / cols;
            c = k % cols;
            if (serp != 0 && (r % 2) == 1) c = cols - 1 - c;
            check_val("valid", 64'(o_valid), 64'd1);
            check_val("busy", 64'(o_busy), 64'd1);
            check_val("row", 64'(o_row), 64'(r));
            check_val("col", 64'(o_col), 64'(c));
            check_val("data", 64'(o_data), snap[r*cols+c] ? 64'h00FF00 : 64'h0);
            check_val("last", 64'(o_last), 64'(k == n - 1));
            check_val("done_early", 64'(o_done), 64'd0);
            rdy = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            ready_v[sel] = rdy;
            if (mutate) begin
                if (cyc == 1) cells_v[sel] = '1;
                if (cyc == 2) start_v[sel] = 1'b1;
                if (cyc == 4) start_v[sel] = 1'b0;
            end
            tick();
            if (rdy) k++;
            cyc++;
        end
        if (k < n) check_val("timeout_pixels", 64'(k), 64'(n));
        ready_v[sel] = 1'b0;
        check_val("done_pulse", 64'(o_done), 64'd1);
        check_val("done_busy", 64'(o_busy), 64'd1);
        check_val("done_valid", 64'(o_valid), 64'd0);
        tick();
        check_val("idle_done", 64'(o_done), 64'd0);
        check_val("idle_busy", 64'(o_busy), 64'd0);
        check_val("idle_valid", 64'(o_valid), 64'd0);
        $display("frame %s: %0d pixels in %0d cycles", tag, k, cyc);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
            cells_v[i] = '0;
        end
        @(negedge clk);
        check_val("rst_busy", 64'(o_busy), 64'd0);
        check_val("rst_valid", 64'(o_valid), 64'd0);
        check_val("rst_last", 64'(o_last), 64'd0);
        check_val("rst_done", 64'(o_done), 64'd0);
        check_val("rst_data", 64'(o_data), 64'd0);
        check_val("rst_row", 64'(o_row), 64'd0);
        check_val("rst_col", 64'(o_col), 64'd0);
        check_val("rst_last_1x1", 64'(last1), 64'd0);
        rst = 1'b1;
        tick();

        // Abort mid-frame with an asynchronous reset at pixel 5.
        cells_v[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("pre_abort_col", 64'(o_col), 64'd5);
        check_val("pre_abort_valid", 64'(o_valid), 64'd1);
        #1 rst = 1'b0;
        #1;
        check_val("abort_valid", 64'(o_valid), 64'd0);
        check_val("abort_busy", 64'(o_busy), 64'd0);
        check_val("abort_col", 64'(o_col), 64'd0);
        ready_v[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("abort_no_done", 64'(o_done), 64'd0);
        end
        rst = 1'b1;
        tick();
        check_val("post_abort_idle", 64'(o_busy), 64'd0);
        run_frame(8, 8, 0, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, "after_abort");

        run_frame(8, 8, 0, 64'h1, 0, 1'b0, "single_live");
        run_frame(8, 8, 0, 64'hA5C3_0F96_1234_8001, 1, 1'b0, "stalled");
        run_frame(8, 8, 0, 64'h0123_4567_89AB_CDEF, 0, 1'b1, "snapshot_hold");

        sel = 1;
        tick();
        run_frame(3, 4, 1, 64'h0000_0000_0000_0A5C, 0, 1'b0, "serp_3x4");
        run_frame(3, 4, 1, 64'h0000_0000_0000_0C31, 1, 1'b0, "serp_3x4_stall");

        sel = 2;
        tick();
        run_frame(1, 1, 0, 64'h1, 0, 1'b0, "one_pixel");
        run_frame(1, 1, 0, 64'h0, 1, 1'b0, "one_pixel_dead");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
